// File: rtl/traffic_pkg.sv
// Shared types and constants for the N-approach traffic-light controller.
// The S_WALK state exists only when TRAFFIC_PED_EN is defined.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
`ifdef TRAFFIC_PED_EN
    ,
    S_WALK   = 2'd3
`endif
  } traffic_state_t;

  localparam logic LAMP_ON  = 1'b1;
  localparam logic LAMP_OFF = 1'b0;

  localparam int unsigned DEF_N_WAY    = 2;
  localparam int unsigned DEF_GREEN_T  = 5;
  localparam int unsigned DEF_YELLOW_T = 2;
  localparam int unsigned DEF_ALLRED_T = 1;
  localparam int unsigned DEF_WALK_T   = 4;
  localparam int unsigned DEF_TICK_DIV = 1;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Free-running tick generator: tick is high once every TICK_DIV clk cycles.
module traffic_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// Round-robin N-approach traffic-light controller with demand skipping.
// Optional pedestrian walk phase enabled by defining TRAFFIC_PED_EN.
module traffic_ctrl_nway
  import traffic_pkg::*;
#(
  parameter int unsigned N_WAY    = DEF_N_WAY,
  parameter int unsigned GREEN_T  = DEF_GREEN_T,
  parameter int unsigned YELLOW_T = DEF_YELLOW_T,
  parameter int unsigned ALLRED_T = DEF_ALLRED_T,
  parameter int unsigned WALK_T   = DEF_WALK_T,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_WAY-1:0]           demand,
  input  logic                       ped_req,
  output logic [N_WAY-1:0]           red,
  output logic [N_WAY-1:0]           yellow,
  output logic [N_WAY-1:0]           green,
  output logic                       walk,
  output logic [$clog2(N_WAY)-1:0]   active_way
);

  localparam int unsigned WW    = $clog2(N_WAY);
  localparam int unsigned MAX_T = max2(max2(GREEN_T, YELLOW_T), max2(ALLRED_T, WALK_T));
  localparam int unsigned TMR_W = $clog2(MAX_T) + 1;

  traffic_state_t   state_q, state_d;
  logic [WW-1:0]    way_q, way_d, next_way;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [N_WAY-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
  logic             walk_q, walk_d;
  logic             tick;
  logic             phase_done;
  int unsigned      dur;

`ifdef TRAFFIC_PED_EN
  logic ped_q, ped_d;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
`endif

  traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Round-robin search from way_q+1; falls back to way_q+1 when nobody has demand.
  always_comb begin
    logic              found;
    logic [WW-1:0]     cand;
    int unsigned       idx;
    found    = 1'b0;
    cand     = '0;
    idx      = 0;
    next_way = (way_q == WW'(N_WAY - 1)) ? '0 : way_q + 1'b1;
    for (int unsigned i = 1; i <= N_WAY; i++) begin
      idx = 32'(way_q) + i;
      if (idx >= N_WAY) idx = idx - N_WAY;
      cand = WW'(idx);
      if (!found && demand[cand]) begin
        found    = 1'b1;
        next_way = cand;
      end
    end
  end

  always_comb begin
    case (state_q)
      S_GREEN:  dur = GREEN_T;
      S_YELLOW: dur = YELLOW_T;
`ifdef TRAFFIC_PED_EN
      S_WALK:   dur = WALK_T;
`endif
      default:  dur = ALLRED_T;
    endcase
  end

  assign phase_done = tick && (timer_q == TMR_W'(dur - 1));

  // Next state, timer, pedestrian latch and the lamp image of the next state.
  always_comb begin
    state_d  = state_q;
    way_d    = way_q;
    timer_d  = timer_q;
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    walk_d   = 1'b0;
`ifdef TRAFFIC_PED_EN
    ped_d    = ped_q | ped_req;
`endif

    if (tick) timer_d = timer_q + 1'b1;

    if (phase_done) begin
      timer_d = '0;
      case (state_q)
        S_GREEN:  state_d = S_YELLOW;
        S_YELLOW: state_d = S_ALLRED;
        S_ALLRED: begin
`ifdef TRAFFIC_PED_EN
          if (ped_q) begin
            state_d = S_WALK;
            ped_d   = 1'b0;
          end else begin
            state_d = S_GREEN;
            way_d   = next_way;
          end
`else
          state_d = S_GREEN;
          way_d   = next_way;
`endif
        end
`ifdef TRAFFIC_PED_EN
        S_WALK:   state_d = S_ALLRED;
`endif
        default:  state_d = S_ALLRED;
      endcase
    end

    case (state_d)
      S_GREEN: begin
        green_d[way_d] = LAMP_ON;
        red_d[way_d]   = LAMP_OFF;
      end
      S_YELLOW: begin
        yellow_d[way_d] = LAMP_ON;
        red_d[way_d]    = LAMP_OFF;
      end
`ifdef TRAFFIC_PED_EN
      S_WALK:  walk_d = LAMP_ON;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_ALLRED;
      way_q    <= WW'(N_WAY - 1);
      timer_q  <= '0;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
      walk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      way_q    <= way_d;
      timer_q  <= timer_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
      walk_q   <= walk_d;
    end
  end

`ifdef TRAFFIC_PED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ped_q <= 1'b0;
    else      ped_q <= ped_d;
  end
`endif

  assign red        = red_q;
  assign yellow     = yellow_q;
  assign green      = green_q;
  assign walk       = walk_q;
  assign active_way = way_q;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench for traffic_ctrl_nway: default, 4-way demand-skip and TICK_DIV=3 instances.
module tb_traffic_ctrl_nway;

  logic clk = 1'b0;
  logic rst;

  logic [1:0] dem2, red2, yel2, grn2;
  logic       ped2, walk2;
  logic [0:0] aw2;

  logic [3:0] dem4, red4, yel4, grn4;
  logic       ped4, walk4;
  logic [1:0] aw4;

  logic [1:0] dem3, red3, yel3, grn3;
  logic       ped3, walk3;
  logic [0:0] aw3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_ctrl_nway dut2 (
    .clk(clk), .rst(rst), .demand(dem2), .ped_req(ped2),
    .red(red2), .yellow(yel2), .green(grn2), .walk(walk2), .active_way(aw2)
  );

  traffic_ctrl_nway #(.N_WAY(4)) dut4 (
    .clk(clk), .rst(rst), .demand(dem4), .ped_req(ped4),
    .red(red4), .yellow(yel4), .green(grn4), .walk(walk4), .active_way(aw4)
  );

  traffic_ctrl_nway #(.TICK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .demand(dem3), .ped_req(ped3),
    .red(red3), .yellow(yel3), .green(grn3), .walk(walk3), .active_way(aw3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({red2, yel2, grn2, walk2, aw2} !== {2'b11, 2'b00, 2'b00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_dut2 got=%b want=%b", {red2, yel2, grn2, walk2, aw2}, 8'b11000001);
    end
    n_checks++;
    if ({red4, yel4, grn4, walk4, aw4} !== {4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd3}) begin
      n_fail++;
      $display("FAIL reset_dut4 got=%b want=%b", {red4, yel4, grn4, walk4, aw4}, 15'b111100000000011);
    end
    n_checks++;
    if ({red3, yel3, grn3, aw3} !== {2'b11, 2'b00, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_dut3 got=%b want=%b", {red3, yel3, grn3, aw3}, 7'b1100001);
    end
  endtask

  // Release reset and follow dut2 through green0, yellow0, all-red, green1.
  task automatic test_reset_release();
    logic [1:0] eg [9];
    logic [1:0] ey [9];
    logic       ea [9];
    logic [1:0] er;
    eg = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    ey = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef TRAFFIC_PED_EN
    ped2 = 1'b0;
`else
    ped2 = 1'b1;
`endif
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      step();
      er = ~(eg[k] | ey[k]);
      n_checks++;
      if ({red2, yel2, grn2, walk2, aw2} !== {er, ey[k], eg[k], 1'b0, ea[k]}) begin
        n_fail++;
        $display("FAIL release_edge%0d got=%b want=%b", k + 1,
                 {red2, yel2, grn2, walk2, aw2}, {er, ey[k], eg[k], 1'b0, ea[k]});
      end
    end
    ped2 = 1'b0;
  endtask

  // Only approach 2 has demand: it must own every green, period 8 cycles.
  task automatic test_demand_skip();
    logic [3:0] eg, ey;
    int p;
    dem4 = 4'b0100;
    apply_reset();
    for (int k = 1; k <= 32; k++) begin
      step();
      p  = (k - 1) % 8;
      eg = (p < 5) ? 4'b0100 : 4'b0000;
      ey = (p == 5 || p == 6) ? 4'b0100 : 4'b0000;
      n_checks++;
      if ({red4, yel4, grn4, walk4, aw4} !== {~(eg | ey), ey, eg, 1'b0, 2'd2}) begin
        n_fail++;
        $display("FAIL skip_edge%0d got=%b want=%b", k,
                 {red4, yel4, grn4, walk4, aw4}, {~(eg | ey), ey, eg, 1'b0, 2'd2});
      end
    end
  endtask

  // TICK_DIV=3: all-red 3, green 15, yellow 6, all-red 3, then approach 1.
  task automatic test_tick_div();
    logic [1:0] eg, ey;
    logic       ea;
    apply_reset();
    for (int k = 1; k <= 32; k++) begin
      step();
      eg = 2'b00;
      ey = 2'b00;
      ea = 1'b0;
      if (k < 3) ea = 1'b1;
      else if (k < 18) eg = 2'b01;
      else if (k < 24) ey = 2'b01;
      else if (k >= 27) begin
        eg = 2'b10;
        ea = 1'b1;
      end
      n_checks++;
      if ({red3, yel3, grn3, aw3} !== {~(eg | ey), ey, eg, ea}) begin
        n_fail++;
        $display("FAIL tickdiv_edge%0d got=%b want=%b", k,
                 {red3, yel3, grn3, aw3}, {~(eg | ey), ey, eg, ea});
      end
    end
  endtask

  // Reset asserted during yellow must blank the lamps before any clock edge.
  task automatic test_mid_reset();
    ped2 = 1'b0;
    apply_reset();
    repeat (6) step();
    n_checks++;
    if (yel2 !== 2'b01) begin
      n_fail++;
      $display("FAIL midreset_pre_yellow got=%b want=%b", yel2, 2'b01);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({red2, yel2, grn2, aw2} !== {2'b11, 2'b00, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_async got=%b want=%b", {red2, yel2, grn2, aw2}, 7'b1100001);
    end
    test_reset_release();
  endtask

`ifdef TRAFFIC_PED_EN
  // One-cycle request in green0 yields walk after yellow and all-red.
  task automatic test_pedestrian();
    logic [1:0] eg [14];
    logic [1:0] ey [14];
    logic       ew [14];
    logic       ea [14];
    eg = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    ey = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ped2 = 1'b0;
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      step();
      if (k == 1) ped2 = 1'b1;
      if (k == 2) ped2 = 1'b0;
      n_checks++;
      if ({red2, yel2, grn2, walk2, aw2} !== {~(eg[k] | ey[k]), ey[k], eg[k], ew[k], ea[k]}) begin
        n_fail++;
        $display("FAIL ped_edge%0d got=%b want=%b", k + 1,
                 {red2, yel2, grn2, walk2, aw2}, {~(eg[k] | ey[k]), ey[k], eg[k], ew[k], ea[k]});
      end
    end
  endtask
`endif

  initial begin
    dem2 = 2'b11;
    dem3 = 2'b11;
    dem4 = 4'b0100;
    ped2 = 1'b0;
    ped3 = 1'b0;
    ped4 = 1'b0;
    test_reset();
    test_reset_release();
    test_demand_skip();
    test_tick_div();
    test_mid_reset();
`ifdef TRAFFIC_PED_EN
    test_pedestrian();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
